modexp_arbiter: RTL and testbench
=================================

MODEXP_ARBITER -- requirements
Module: modexp_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of requesters.
REQ-002 SHALL have parameter WIDTH, default 32: operand and result width.
REQ-003 SHALL have parameter IDW, default 2: requester-ID width, and SHALL require 2^IDW >= NREQ.
REQ-004 SHALL have parameter WDOG_CYCLES, default 256: engine timeout in cycles, used only under the configuration macro.
REQ-005 Port clk, input, 1: clock; all logic on its rising edge.
REQ-006 Port rst, input, 1: reset, synchronous, active-high.
REQ-007 Port req_valid, input, NREQ: per-requester request valid.
REQ-008 Port req_ready, output, NREQ: per-requester accept.
REQ-009 Port req_base, input, NREQ*WIDTH: packed bases; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-010 Port req_exp, input, NREQ*WIDTH: packed exponents, same packing as req_base.
REQ-011 Port rsp_valid, output, 1: response valid.
REQ-012 Port rsp_ready, input, 1: response accept.
REQ-013 Port rsp_id, output, IDW: index of the requester that owns the response.
REQ-014 Port rsp_result, output, WIDTH: base^exp mod MOD.
REQ-015 Port rsp_err, output, 1: response is a timeout error.
REQ-016 Port eng_rst, output, 1: reset to the shared modexp engine.
REQ-017 Port eng_start, output, 1: engine start.
REQ-018 Port eng_base and eng_exp, output, WIDTH each: engine operands.
REQ-019 Port eng_done, input, 1: engine done level; it stays high until start is low.
REQ-020 Port eng_result, input, WIDTH: engine result.
REQ-021 Port busy, output, 1: high in every state except IDLE.

Function
REQ-022 SHALL use FSM states IDLE, ISSUE, WAIT, RESP and DRAIN.
REQ-023 IDLE: if any req_valid is high, SHALL grant by round-robin, searching from (last_grant+1) mod NREQ and wrapping.
REQ-024 IDLE, on grant: SHALL assert req_ready only for the granted index, combinationally, in the same cycle.
REQ-025 IDLE, on grant: SHALL latch base, exp and ID into operand registers, update last_grant, and go to ISSUE.
REQ-026 SHALL never assert more than one req_ready bit, and SHALL assert none outside IDLE.
REQ-027 ISSUE: SHALL assert eng_start for exactly one cycle with eng_base and eng_exp from the operand registers, then go to WAIT.
REQ-028 eng_base and eng_exp SHALL stay stable from ISSUE until leaving WAIT.
REQ-029 WAIT: when eng_done is high, SHALL capture eng_result into rsp_result, set rsp_valid, and go to RESP.
REQ-030 RESP: SHALL hold rsp_valid, rsp_id, rsp_result and rsp_err stable until rsp_ready is high.
REQ-031 RESP, on handshake: SHALL clear rsp_valid and go to DRAIN.
REQ-032 DRAIN: SHALL wait for eng_done low, then go to IDLE; a new start SHALL never coincide with a stale done.
REQ-033 Request acceptance SHALL take exactly one cycle after req_valid&req_ready; rsp_valid SHALL rise one cycle after eng_done is first sampled high.
REQ-034 When all NREQ requesters are continuously valid, grants SHALL rotate 0,1,...,NREQ-1,0 with no starvation.
REQ-035 Requests arriving while busy SHALL be held off by req_ready=0 and SHALL NOT be dropped.
REQ-036 The arbiter SHALL drive eng_rst = rst, OR'd with the timeout pulse when the configuration macro is defined.

Reset
REQ-037 While rst is high: state=IDLE; last_grant=NREQ-1, so requester 0 wins first.
REQ-038 While rst is high: rsp_valid=0, rsp_err=0, rsp_id=0, rsp_result=0, eng_start=0, req_ready=0, busy=0, eng_rst=1.
REQ-039 rst mid-operation SHALL abort any in-flight request with no response, and SHALL reset the engine via eng_rst.

Configuration
REQ-040 Macro MODEXP_ARB_WDOG_EN, when defined: a cycle counter SHALL clear on entry to WAIT and increment each WAIT cycle.
REQ-041 Under MODEXP_ARB_WDOG_EN: if the count reaches WDOG_CYCLES without eng_done, the arbiter SHALL pulse eng_rst for one cycle and enter RESP with rsp_err=1 and rsp_result=0.
REQ-042 Under MODEXP_ARB_WDOG_EN: after a timeout response is accepted, DRAIN SHALL proceed as for a normal response.
REQ-043 Without MODEXP_ARB_WDOG_EN: there SHALL be no counter, rsp_err SHALL be tied 0, and WAIT SHALL be unbounded.

Verification
REQ-044 Single request: req 1, base=3, exp=4, rsp_ready=1 -> one response, rsp_id=1, rsp_result=81, rsp_err=0; req_ready[1] high for exactly one cycle.
REQ-045 All four requesters valid together: (2,10), (5,3), (7,0), (3,4) -> responses in ID order 0,1,2,3 with results 1024, 125, 1, 81; eng_start pulses once per job.
REQ-046 Backpressure: rsp_ready held 0 for 20 cycles -> rsp_valid, rsp_id and rsp_result stable; no new req_ready and no eng_start until the handshake.
REQ-047 rst asserted 5 cycles into WAIT -> all outputs at reset values next cycle; eng_rst high; the next request after reset completes correctly.
REQ-048 With MODEXP_ARB_WDOG_EN and WDOG_CYCLES=8, engine model never raising done -> rsp_err=1, rsp_result=0 after 8 WAIT cycles; one-cycle eng_rst pulse; the next request is served normally.

Source files
------------

// File: rtl/modexp_arbiter.sv
// Round-robin arbiter sharing one modexp engine between NREQ requesters.
// Define MODEXP_ARB_WDOG_EN to add an engine watchdog (WDOG_CYCLES) that returns rsp_err on timeout.
module modexp_arbiter #(
  parameter int NREQ        = 4,
  parameter int WIDTH       = 32,
  parameter int IDW         = 2,
  parameter int WDOG_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_base,
  input  logic [NREQ*WIDTH-1:0] req_exp,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_result,
  output logic                  rsp_err,
  output logic                  eng_rst,
  output logic                  eng_start,
  output logic [WIDTH-1:0]      eng_base,
  output logic [WIDTH-1:0]      eng_exp,
  input  logic                  eng_done,
  input  logic [WIDTH-1:0]      eng_result,
  output logic                  busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  if (((1 << IDW) < NREQ) || (WDOG_CYCLES < 1)) begin : g_bad_params
    $error("modexp_arbiter: need 2**IDW >= NREQ and WDOG_CYCLES >= 1");
  end

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, DRAIN} state_e;

  state_e               state_q, state_d;
  logic [IW-1:0]        last_grant_q, last_grant_d;
  logic [WIDTH-1:0]     base_q, base_d, exp_q, exp_d;
  logic [IDW-1:0]       id_q, id_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]     rsp_result_q, rsp_result_d;
  logic [NREQ-1:0]      req_ready_c;
  logic                 eng_start_c;
  logic                 grant_vld;
  logic [IW-1:0]        grant_idx;

  logic [NREQ-1:0][WIDTH-1:0] base_arr, exp_arr;
  assign base_arr = req_base;
  assign exp_arr  = req_exp;

`ifdef MODEXP_ARB_WDOG_EN
  localparam int CW = $clog2(WDOG_CYCLES + 1);
  logic [CW-1:0] wdog_cnt_q, wdog_cnt_d;
  logic          wdog_rst_q, wdog_rst_d;
  logic          rsp_err_q, rsp_err_d;
`endif

  // Search starts just past the last grant so a continuously-valid requester cannot starve others.
  always_comb begin
    int k;
    k         = 0;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      k = int'(last_grant_q) + 1 + i;
      if (k >= NREQ) k = k - NREQ;
      if (!grant_vld && req_valid[IW'(k)]) begin
        grant_vld = 1'b1;
        grant_idx = IW'(k);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    base_d       = base_q;
    exp_d        = exp_q;
    id_d         = id_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    req_ready_c  = '0;
    eng_start_c  = 1'b0;
`ifdef MODEXP_ARB_WDOG_EN
    wdog_cnt_d   = wdog_cnt_q;
    wdog_rst_d   = 1'b0;
    rsp_err_d    = rsp_err_q;
`endif
    case (state_q)
      IDLE: if (grant_vld) begin
        req_ready_c[grant_idx] = 1'b1;
        base_d       = base_arr[grant_idx];
        exp_d        = exp_arr[grant_idx];
        id_d         = IDW'(grant_idx);
        last_grant_d = grant_idx;
        state_d      = ISSUE;
      end
      ISSUE: begin
        eng_start_c = 1'b1;
`ifdef MODEXP_ARB_WDOG_EN
        wdog_cnt_d  = '0;
`endif
        state_d     = WAIT;
      end
      WAIT: begin
        if (eng_done) begin
          rsp_result_d = eng_result;
          rsp_valid_d  = 1'b1;
`ifdef MODEXP_ARB_WDOG_EN
          rsp_err_d    = 1'b0;
`endif
          state_d      = RESP;
        end
`ifdef MODEXP_ARB_WDOG_EN
        // Count reaching WDOG_CYCLES on this cycle: abandon the job and kick the engine.
        else if (wdog_cnt_q == CW'(WDOG_CYCLES - 1)) begin
          rsp_result_d = '0;
          rsp_err_d    = 1'b1;
          rsp_valid_d  = 1'b1;
          wdog_rst_d   = 1'b1;
          state_d      = RESP;
        end else begin
          wdog_cnt_d   = wdog_cnt_q + 1'b1;
        end
`endif
      end
      RESP: if (rsp_ready) begin
        rsp_valid_d = 1'b0;
        state_d     = DRAIN;
      end
      // Stale done must drop before the next start can be issued.
      DRAIN: if (!eng_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= IW'(NREQ - 1);
      base_q       <= '0;
      exp_q        <= '0;
      id_q         <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
`ifdef MODEXP_ARB_WDOG_EN
      wdog_cnt_q   <= '0;
      wdog_rst_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      base_q       <= base_d;
      exp_q        <= exp_d;
      id_q         <= id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
`ifdef MODEXP_ARB_WDOG_EN
      wdog_cnt_q   <= wdog_cnt_d;
      wdog_rst_q   <= wdog_rst_d;
      rsp_err_q    <= rsp_err_d;
`endif
    end
  end

  // Handshake outputs are masked during reset so nothing is granted or started while rst is high.
  assign req_ready  = rst ? '0 : req_ready_c;
  assign eng_start  = eng_start_c & ~rst;
  assign rsp_valid  = rsp_valid_q & ~rst;
  assign busy       = (state_q != IDLE) & ~rst;
  assign rsp_id     = id_q;
  assign rsp_result = rsp_result_q;
  assign eng_base   = base_q;
  assign eng_exp    = exp_q;
`ifdef MODEXP_ARB_WDOG_EN
  assign rsp_err    = rsp_err_q;
  assign eng_rst    = rst | wdog_rst_q;
`else
  assign rsp_err    = 1'b0;
  assign eng_rst    = rst;
`endif

endmodule

// File: tb/tb_modexp_arbiter.sv
// Self-checking bench for modexp_arbiter: vector table plus scoreboard, with a behavioural engine model.
module tb_modexp_arbiter;
  localparam int NREQ = 4, WIDTH = 32, IDW = 2;
`ifdef MODEXP_ARB_WDOG_EN
  localparam int WD = 8;
`else
  localparam int WD = 256;
`endif
  localparam int LAT = 3, HOLD = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid, req_ready;
  logic [NREQ*WIDTH-1:0] req_base, req_exp;
  logic                  rsp_valid, rsp_ready, rsp_err;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_result, eng_base, eng_exp, eng_result;
  logic                  eng_rst, eng_start, eng_done, busy;

  modexp_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW), .WDOG_CYCLES(WD)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_base(req_base), .req_exp(req_exp), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_err(rsp_err), .eng_rst(eng_rst),
    .eng_start(eng_start), .eng_base(eng_base), .eng_exp(eng_exp), .eng_done(eng_done),
    .eng_result(eng_result), .busy(busy));

  always #5 clk = ~clk;

  typedef struct {int id; logic [31:0] base; logic [31:0] ex; logic [31:0] res;} vec_t;
  typedef struct {int id; logic [31:0] res; logic err;} exp_t;

  vec_t vt[8];
  exp_t sb[$];
  int   checks = 0, errors = 0;
  int   cyc = 0, start_cnt = 0, start_cyc = 0, rise_cyc = 0, rsp_cnt = 0, wrst_cnt = 0;
  int   rdy_cnt[NREQ];
  logic prev_rsp_valid = 1'b0;
  logic hang = 1'b0;

  function automatic logic [31:0] modpow(logic [31:0] b, logic [31:0] e);
    logic [31:0] r, p;
    r = 32'd1; p = b;
    for (int i = 0; i < 32; i++) begin
      if (e[i]) r = r * p;
      p = p * p;
    end
    return r;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  // Engine model: done rises LAT cycles after start and stays high HOLD extra cycles.
  int          eng_cnt = 0, eng_hold = 0;
  logic        eng_run = 1'b0;
  always @(posedge clk) begin
    if (eng_rst) begin
      eng_done <= 1'b0; eng_run <= 1'b0; eng_cnt <= 0;
    end else if (eng_start) begin
      eng_run <= 1'b1; eng_cnt <= LAT; eng_done <= 1'b0;
      eng_result <= modpow(eng_base, eng_exp);
    end else if (eng_run && !hang) begin
      if (eng_cnt == 0) begin eng_done <= 1'b1; eng_run <= 1'b0; eng_hold <= HOLD; end
      else eng_cnt <= eng_cnt - 1;
    end else if (eng_done) begin
      if (eng_hold == 0) eng_done <= 1'b0;
      else eng_hold <= eng_hold - 1;
    end
  end

  // Monitor: samples on the falling edge, retires accepted requests after the next rising edge.
  always begin
    logic [NREQ-1:0] acc;
    exp_t e;
    @(negedge clk);
    cyc++;
    acc = req_valid & req_ready;
    for (int i = 0; i < NREQ; i++) rdy_cnt[i] += int'(req_ready[i]);
    if (req_ready != '0) begin
      chk("ready_onehot", 64'($countones(req_ready)), 64'd1);
      chk("ready_only_idle", 64'(busy), 64'd0);
    end
    if (eng_start) begin
      start_cnt++; start_cyc = cyc;
      chk("start_vs_stale_done", 64'(eng_done), 64'd0);
    end
    if (eng_rst && !rst) wrst_cnt++;
    if (rsp_valid && !prev_rsp_valid) rise_cyc = cyc;
    prev_rsp_valid = rsp_valid;
    if (rsp_valid && rsp_ready) begin
      rsp_cnt++;
      if (sb.size() == 0) chk("unexpected_rsp", 64'(rsp_id), 64'hFFFF);
      else begin
        e = sb.pop_front();
        chk("rsp_id", 64'(rsp_id), 64'(e.id));
        chk("rsp_result", 64'(rsp_result), 64'(e.res));
        chk("rsp_err", 64'(rsp_err), 64'(e.err));
      end
    end
    @(posedge clk); #1;
    req_valid = req_valid & ~acc;
  end

  task automatic tick(); @(posedge clk); #2; endtask

  task automatic drive(vec_t v, bit push, bit err = 1'b0);
    exp_t e;
    req_base[v.id*WIDTH +: WIDTH] = v.base;
    req_exp[v.id*WIDTH +: WIDTH]  = v.ex;
    req_valid[v.id] = 1'b1;
    if (push) begin
      e.id = v.id; e.res = err ? 32'd0 : v.res; e.err = err;
      sb.push_back(e);
    end
  endtask

  task automatic wait_idle(string name);
    int n = 0;
    while (!(sb.size() == 0 && req_valid == '0 && !busy) && n < 500) begin tick(); n++; end
    if (n >= 500) chk({name, "_timeout"}, 64'(sb.size()), 64'd0);
  endtask

  task automatic wait_sig(string name, bit on_start);
    int n = 0, s = start_cnt;
    while (n < 300 && (on_start ? (start_cnt == s) : !rsp_valid)) begin tick(); n++; end
    if (n >= 300) chk({name, "_timeout"}, 64'(n), 64'd0);
  endtask

  initial begin
    int s, r, r0;
    logic [IDW-1:0] hid;
    logic [WIDTH-1:0] hres;
    vt[0] = '{1, 32'd3, 32'd4, 32'd81};
    vt[1] = '{0, 32'd2, 32'd10, 32'd1024};
    vt[2] = '{1, 32'd5, 32'd3, 32'd125};
    vt[3] = '{2, 32'd7, 32'd0, 32'd1};
    vt[4] = '{3, 32'd3, 32'd4, 32'd81};
    vt[5] = '{2, 32'hFFFF_FFFF, 32'd2, 32'd1};
    vt[6] = '{3, 32'd6, 32'd2, 32'd36};
    vt[7] = '{3, 32'd2, 32'd31, 32'h8000_0000};
    for (int i = 0; i < NREQ; i++) rdy_cnt[i] = 0;
    rst = 1'b1; rsp_ready = 1'b1; req_valid = '0; req_base = '0; req_exp = '0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_eng_rst", 64'(eng_rst), 64'd1);
    chk("rst_eng_start", 64'(eng_start), 64'd0);
    chk("rst_rsp_id", 64'(rsp_id), 64'd0);
    chk("rst_rsp_result", 64'(rsp_result), 64'd0);
    chk("rst_rsp_err", 64'(rsp_err), 64'd0);
    tick(); rst = 1'b0;

    // All four together: grant order 0,1,2,3 from reset, one start per job.
    s = start_cnt;
    for (int i = 1; i <= 4; i++) drive(vt[i], 1'b1);
    wait_idle("four");
    chk("four_starts", 64'(start_cnt - s), 64'd4);

    // Single request on requester 1.
    r = rdy_cnt[1]; r0 = rsp_cnt;
    drive(vt[0], 1'b1);
    wait_idle("single");
    chk("single_ready_cycles", 64'(rdy_cnt[1] - r), 64'd1);
    chk("single_rsp_count", 64'(rsp_cnt - r0), 64'd1);

    // Backpressure with a second request held off behind it.
    rsp_ready = 1'b0;
    drive(vt[5], 1'b1);
    wait_sig("bp_valid", 1'b0);
    drive(vt[6], 1'b1);
    hid = rsp_id; hres = rsp_result; s = start_cnt; r = rdy_cnt[3];
    chk("bp_first_id", 64'(hid), 64'd2);
    for (int i = 0; i < 20; i++) begin
      tick(); @(negedge clk);
      if (!(rsp_valid && rsp_id == hid && rsp_result == hres)) chk("bp_stable", {rsp_valid, rsp_id, rsp_result}, {1'b1, hid, hres});
    end
    checks++;
    chk("bp_no_start", 64'(start_cnt - s), 64'd0);
    chk("bp_no_ready", 64'(rdy_cnt[3] - r), 64'd0);
    chk("bp_req_held", 64'(req_valid[3]), 64'd1);
    tick(); rsp_ready = 1'b1;
    wait_idle("bp");

    // Reset five cycles into WAIT on an engine that never finishes.
    hang = 1'b1;
    drive(vt[3], 1'b0);
    wait_sig("rst_start", 1'b1);
    repeat (5) tick();
    chk("pre_rst_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_eng_rst", 64'(eng_rst), 64'd1);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    tick(); @(negedge clk);
    chk("mid_rst_rsp_id", 64'(rsp_id), 64'd0);
    chk("mid_rst_rsp_result", 64'(rsp_result), 64'd0);
    chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    tick(); rst = 1'b0; hang = 1'b0;
    // Requester 0 must win over 3 right after reset.
    drive(vt[1], 1'b1); drive(vt[7], 1'b1);
    wait_idle("post_rst");

`ifdef MODEXP_ARB_WDOG_EN
    hang = 1'b1; r = wrst_cnt;
    drive(vt[0], 1'b1, 1'b1);
    wait_sig("wdog_valid", 1'b0);
    chk("wdog_latency", 64'(rise_cyc - start_cyc), 64'd9);
    wait_idle("wdog");
    chk("wdog_eng_rst_pulses", 64'(wrst_cnt - r), 64'd1);
    hang = 1'b0;
    drive(vt[0], 1'b1);
    wait_idle("wdog_after");
`endif

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: cycles %0d", cyc);
    $fatal(1, "timeout");
  end
endmodule
